// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage arithmetic blocks.
//   div_state_t - sequential divider control states (IDLE / BUSY / DONE)
//   cnt_width() - iteration counter width for a given operand width
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: xlen-bit ripple-carry adder.
//   a, b       - addends
//   carry_in   - carry into bit 0
//   sum        - a + b + carry_in, truncated to xlen bits
//   carry_out  - carry out of the top bit
module ripple_carry_adder #(
  parameter int unsigned xlen = 32
) (
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            carry_in,
  output logic [xlen-1:0] sum,
  output logic            carry_out
);

  // Carry is a process-local variable so the chain does not form a
  // combinational loop through a vector signal.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = carry_in;
    for (int unsigned i = 0; i < xlen; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carry_out = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per cycle.
//   clk, rst   - clock, synchronous active-high reset
//   start      - request a division (accepted while ready=1)
//   dividend   - numerator, sampled on the accepting edge
//   divisor    - denominator, sampled on the accepting edge
//   signed_op  - only with SEQ_DIVIDER_SIGNED_EN: two's-complement operands
//   ready      - high in IDLE and DONE
//   done       - one-cycle pulse, results valid in that cycle
//   quotient   - result, held until the next DONE or reset
//   remainder  - result, held until the next DONE or reset
// Divide by zero yields quotient all-ones, remainder = dividend, with no
// special path: a zero divisor never borrows.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned xlen = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [xlen-1:0] dividend,
  input  logic [xlen-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic            signed_op,
`endif
  output logic            ready,
  output logic            done,
  output logic [xlen-1:0] quotient,
  output logic [xlen-1:0] remainder
);

  localparam int unsigned CW = cnt_width(xlen);

  div_state_t      state, state_next;
  logic [CW-1:0]   cnt;
  logic [xlen:0]   p, p_sh, d_inv, diff, p_next;
  logic [xlen-1:0] q, d, q_next;
  logic [xlen-1:0] mag_a, mag_b, q_res, r_res;
  logic            no_borrow, accept, last_iter;
  logic            unused_p_msb;

  assign accept    = start & ready;
  assign last_iter = (state == BUSY) && (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = start ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    done  = (state == DONE);
  end

  // Trial subtraction P - D as P + ~D + 1; carry-out 1 means no borrow.
  assign p_sh  = {p[xlen-1:0], q[xlen-1]};
  assign d_inv = ~{1'b0, d};

  ripple_carry_adder #(.xlen(xlen + 1)) u_sub (
    .a         (p_sh),
    .b         (d_inv),
    .carry_in  (1'b1),
    .sum       (diff),
    .carry_out (no_borrow)
  );

  assign p_next = no_borrow ? diff : p_sh;
  assign q_next = {q[xlen-2:0], no_borrow};

  // P stays below D after every iteration, so its top bit never feeds back.
  assign unused_p_msb = p[xlen];

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  always_comb begin
    a_neg = signed_op & dividend[xlen-1];
    b_neg = signed_op & divisor[xlen-1];
    mag_a = a_neg ? (~dividend + 1'b1) : dividend;
    mag_b = b_neg ? (~divisor + 1'b1) : divisor;
    q_res = neg_q ? (~q_next + 1'b1) : q_next;
    r_res = neg_r ? (~p_next[xlen-1:0] + 1'b1) : p_next[xlen-1:0];
  end

  // A zero divisor keeps the all-ones quotient unnegated.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= (a_neg ^ b_neg) & (divisor != '0);
      neg_r <= a_neg;
    end
  end
`else
  always_comb begin
    mag_a = dividend;
    mag_b = divisor;
    q_res = q_next;
    r_res = p_next[xlen-1:0];
  end
`endif

  // Datapath: Q register holds the remaining dividend bits in its upper
  // part and collects quotient bits from the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      p         <= '0;
      q         <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt <= CW'(xlen - 1);
      p   <= '0;
      q   <= mag_a;
      d   <= mag_b;
    end else if (state == BUSY) begin
      p <= p_next;
      q <= q_next;
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (last_iter) begin
        quotient  <= q_res;
        remainder <= r_res;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [XLEN-1:0] dividend = '0;
  logic [XLEN-1:0] divisor = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic            signed_op = 1'b0;
`endif
  logic            ready, done;
  logic [XLEN-1:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q, exp_r;

  always #5 clk = ~clk;

  seq_divider #(.xlen(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op (signed_op),
`endif
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RISC-V div/rem semantics from plain arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    chk("ready_at_issue", {31'd0, ready}, 32'd1);
    model(a, b, sgn, exp_q, exp_r);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
    signed_op = sgn;
`endif
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_result(input string tag, input int lat0);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    bit seen;
    bit sgn;
    logic [31:0] a, b;

    // Reset with start held high
    rst = 1'b1; start = 1'b1; dividend = 32'd53; divisor = 32'd5;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_no_start", {31'd0, ready}, 32'd1);

    // 53 / 5 and hold
    issue(32'd53, 32'd5, 1'b0);
    wait_result("d53_5", 1);
    repeat (3) @(negedge clk);
    chk("hold_quotient", quotient, 32'd10);
    chk("hold_remainder", remainder, 32'd3);
    chk("hold_done", {31'd0, done}, 32'd0);

    // Divide by zero
    issue(32'd7, 32'd0, 1'b0);
    wait_result("d7_0", 1);
    chk("dz_quotient_const", quotient, 32'hFFFF_FFFF);

    // Back-to-back: start held in DONE cycle
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_result("dmax_1", 1);
    issue(32'd100, 32'd7, 1'b0);
    wait_result("d100_7_b2b", 1);
    chk("b2b_quotient_const", quotient, 32'd14);

    // start pulses during BUSY are ignored
    issue(32'd12345, 32'd67, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("busy_not_ready", {31'd0, ready}, 32'd0);
      start    = 1'($urandom_range(0, 1));
      dividend = $urandom;
      divisor  = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    wait_result("interfere", 11);

    // Reset mid-BUSY aborts with no done
    issue(32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_result("s_m7_2", 1);
    chk("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("s_ovf", 1);
    issue(32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_result("s_m7_0", 1);
    chk("s_m7_0_r_const", remainder, 32'hFFFF_FFF9);
`endif

    // Randomized operations, mixed back-to-back and idle gaps
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(a, b, sgn);
      wait_result("rand", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
